// File: rtl/calc_key_entry.sv
// Key-entry sequencer for the one-digit BCD calculator: drives adder operands and latches its result.
// Optional chained operation from a shown result is enabled by defining CALC_CHAIN_EN.
module calc_key_entry (
   input  logic       CLK,
   input  logic       RST_X,
   input  logic       KEY_VALID,
   input  logic [3:0] KEY_CODE,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic       SUB,
   input  logic [3:0] S,
   input  logic       CARRY,
   output logic [3:0] RES,
   output logic       RES_CARRY,
   output logic       RES_VALID,
   output logic [3:0] DISP,
   output logic       ERR
);

   localparam logic [1:0] S_X   = 2'd0;
   localparam logic [1:0] S_OP  = 2'd1;
   localparam logic [1:0] S_Y   = 2'd2;
   localparam logic [1:0] S_RES = 2'd3;

   logic [1:0] state_q, state_d;
   logic [3:0] x_q, x_d;
   logic [3:0] y_q, y_d;
   logic       sub_q, sub_d;
   logic [3:0] res_q, res_d;
   logic       res_carry_q, res_carry_d;
   logic       res_valid_q, res_valid_d;
   logic [3:0] disp_q, disp_d;
   logic       err_q, err_d;

   logic key_digit, key_op, key_eq, key_clr;

   assign key_digit = KEY_VALID && (KEY_CODE <= 4'd9);
   assign key_op    = KEY_VALID && ((KEY_CODE == 4'hA) || (KEY_CODE == 4'hB));
   assign key_eq    = KEY_VALID && (KEY_CODE == 4'hC);
   assign key_clr   = KEY_VALID && (KEY_CODE == 4'hD);

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      sub_d       = sub_q;
      res_d       = res_q;
      res_carry_d = res_carry_q;
      res_valid_d = 1'b0;
      err_d       = err_q;

      if (key_clr) begin
         state_d     = S_X;
         x_d         = 4'd0;
         y_d         = 4'd0;
         sub_d       = 1'b0;
         res_d       = 4'd0;
         res_carry_d = 1'b0;
         err_d       = 1'b0;
      end else begin
         case (state_q)
            S_X: begin
               if (key_digit) x_d = KEY_CODE;
               if (key_op) begin
                  sub_d   = KEY_CODE[0];
                  state_d = S_OP;
               end
            end
            S_OP: begin
               if (key_digit) begin
                  y_d     = KEY_CODE;
                  state_d = S_Y;
               end
               if (key_op) sub_d = KEY_CODE[0];
            end
            S_Y: begin
               if (key_digit) y_d = KEY_CODE;
               // Adder output is combinational on the X/Y/SUB held this cycle.
               if (key_eq) begin
                  res_d       = S;
                  res_carry_d = CARRY;
                  res_valid_d = 1'b1;
                  state_d     = S_RES;
               end
            end
            default: begin
               if (key_digit) begin
                  x_d     = KEY_CODE;
                  y_d     = 4'd0;
                  sub_d   = 1'b0;
                  err_d   = 1'b0;
                  state_d = S_X;
               end
`ifdef CALC_CHAIN_EN
               if (key_op) begin
                  if (res_carry_q) begin
                     err_d = 1'b1;
                  end else begin
                     x_d     = res_q;
                     sub_d   = KEY_CODE[0];
                     state_d = S_OP;
                  end
               end
`endif
            end
         endcase
      end

`ifndef CALC_CHAIN_EN
      err_d = 1'b0;
`endif

      case (state_d)
         S_X, S_OP: disp_d = x_d;
         S_Y:       disp_d = y_d;
         default:   disp_d = res_d;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_q     <= S_X;
         x_q         <= 4'd0;
         y_q         <= 4'd0;
         sub_q       <= 1'b0;
         res_q       <= 4'd0;
         res_carry_q <= 1'b0;
         res_valid_q <= 1'b0;
         disp_q      <= 4'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         sub_q       <= sub_d;
         res_q       <= res_d;
         res_carry_q <= res_carry_d;
         res_valid_q <= res_valid_d;
         disp_q      <= disp_d;
         err_q       <= err_d;
      end
   end

   assign X         = x_q;
   assign Y         = y_q;
   assign SUB       = sub_q;
   assign RES       = res_q;
   assign RES_CARRY = res_carry_q;
   assign RES_VALID = res_valid_q;
   assign DISP      = disp_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Bench for calc_key_entry: behavioural BCD adder plus a key-level reference model,
// directed calculator scenarios followed by random key streams.
module tb_calc_key_entry;

   logic       CLK = 1'b0;
   logic       RST_X = 1'b0;
   logic       KEY_VALID = 1'b0;
   logic [3:0] KEY_CODE = 4'd0;
   logic [3:0] X, Y, S, RES, DISP;
   logic       SUB, CARRY, RES_CARRY, RES_VALID, ERR;

   int total = 0;
   int bad   = 0;

   // Reference model: what the user has entered so far, in calculator terms.
   int  m_x, m_y, m_res, m_disp;
   bit  m_sub, m_carry, m_rv, m_err;
   bit  m_have_op, m_have_y, m_showing;

   calc_key_entry dut (
      .CLK(CLK), .RST_X(RST_X), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
      .X(X), .Y(Y), .SUB(SUB), .S(S), .CARRY(CARRY),
      .RES(RES), .RES_CARRY(RES_CARRY), .RES_VALID(RES_VALID),
      .DISP(DISP), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // One-digit BCD add/subtract: result digit in [3:0], carry/borrow in [4].
   function automatic logic [4:0] bcd_calc(input int a, input int b, input bit sub);
      int t;
      if (!sub) begin
         t = a + b;
         return (t > 9) ? {1'b1, 4'(t - 10)} : {1'b0, 4'(t)};
      end
      return (a >= b) ? {1'b0, 4'(a - b)} : {1'b1, 4'(a + 10 - b)};
   endfunction

   assign {CARRY, S} = bcd_calc(int'(X), int'(Y), SUB);

   task automatic model_clear();
      m_x = 0; m_y = 0; m_res = 0; m_sub = 0; m_carry = 0; m_err = 0;
      m_have_op = 0; m_have_y = 0; m_showing = 0;
   endtask

   task automatic model_key(input bit rst_n, input bit vld, input int code);
      logic [4:0] r;
      m_rv = 0;
      if (!rst_n || (vld && code == 13)) begin
         model_clear();
      end else if (vld && code <= 9) begin
         if (m_showing) begin
            m_x = code; m_y = 0; m_sub = 0; m_err = 0; m_showing = 0;
         end else if (m_have_op) begin
            m_y = code; m_have_y = 1;
         end else begin
            m_x = code;
         end
      end else if (vld && (code == 10 || code == 11)) begin
         if (m_showing) begin
`ifdef CALC_CHAIN_EN
            if (m_carry) m_err = 1;
            else begin
               m_x = m_res; m_sub = (code == 11); m_showing = 0;
               m_have_op = 1; m_have_y = 0;
            end
`endif
         end else if (!m_have_y) begin
            m_sub = (code == 11); m_have_op = 1;
         end
      end else if (vld && code == 12 && m_have_y && !m_showing) begin
         r = bcd_calc(m_x, m_y, m_sub);
         m_res = int'(r[3:0]); m_carry = r[4]; m_rv = 1;
         m_showing = 1; m_have_op = 0; m_have_y = 0;
      end
      m_disp = m_showing ? m_res : (m_have_y ? m_y : m_x);
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".X"}, int'(X), m_x);
      check({tag, ".Y"}, int'(Y), m_y);
      check({tag, ".SUB"}, int'(SUB), int'(m_sub));
      check({tag, ".RES"}, int'(RES), m_res);
      check({tag, ".RES_CARRY"}, int'(RES_CARRY), int'(m_carry));
      check({tag, ".RES_VALID"}, int'(RES_VALID), int'(m_rv));
      check({tag, ".DISP"}, int'(DISP), m_disp);
      check({tag, ".ERR"}, int'(ERR), int'(m_err));
   endtask

   task automatic step(input bit rst_n, input bit vld, input int code);
      @(negedge CLK);
      RST_X = rst_n; KEY_VALID = vld; KEY_CODE = 4'(code);
      @(posedge CLK);
      model_key(rst_n, vld, code);
      #1;
   endtask

   task automatic key(input int code);
      step(1'b1, 1'b1, code);
   endtask

   initial begin
      int seq_add[4]   = '{3, 10, 5, 12};
      int seq_ovf[5]   = '{4, 9, 10, 9, 12};
      int seq_opchg[7] = '{7, 10, 11, 12, 6, 14, 12};
      int seq_chain[11] = '{1, 10, 8, 12, 10, 0, 12, 9, 10, 9, 12};

      model_clear();
      step(1'b0, 1'b1, 7);
      check_all("reset");

      key(7);
      check("entry7.X", int'(X), 7);
      step(1'b0, 1'b0, 0);
      check_all("reset_mid");
      check("reset_mid.DISP0", int'(DISP), 0);

      foreach (seq_add[i]) begin
         key(seq_add[i]);
         check_all("add");
      end
      check("add.RES8", int'(RES), 8);
      check("add.pulse", int'(RES_VALID), 1);
      step(1'b1, 1'b0, 0);
      check_all("add_idle");
      check("add.pulse_off", int'(RES_VALID), 0);

      key(13);
      check_all("clear");
      foreach (seq_ovf[i]) begin
         key(seq_ovf[i]);
         check_all("ovf");
      end
      check("ovf.RES", int'(RES), 8);
      check("ovf.CARRY", int'(RES_CARRY), 1);

      key(13);
      foreach (seq_opchg[i]) begin
         key(seq_opchg[i]);
         check_all("opchg");
      end
      check("opchg.RES1", int'(RES), 1);
      check("opchg.SUB", int'(SUB), 1);

      key(13);
      foreach (seq_chain[i]) begin
         key(seq_chain[i]);
         check_all("chain");
      end
      key(10);
      check_all("chain_plus");
      key(11);
      check_all("chain_minus");
      key(12);
      check_all("chain_eq_in_res");
      key(2);
      check_all("restart");
      check("restart.DISP2", int'(DISP), 2);

      // Re-enter S_RES then clear it.
      key(5); key(10); key(4); key(12);
      check_all("res_again");
      key(13);
      check_all("clear_res");

      for (int n = 0; n < 3000; n++) begin
         int c;
         bit v, r;
         r = ($urandom_range(0, 99) != 0);
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9)
                                         : $urandom_range(10, 15);
         if (c == 13 && $urandom_range(0, 3) != 0) c = 12;
         step(r, v, c);
         check_all("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
